// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART transmitter: start, LSB-first data, optional parity, stop
// Each bit is held for max(prescale,1) clocks; frame settings are latched at acceptance.
module uart_tx_frame #(
  parameter int data_width     = 8,
  parameter int prescale_width = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [data_width-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [prescale_width-1:0] prescale,
  output logic                      TX_OUT,
  output logic                      Busy
);

  localparam int idx_width = $clog2(data_width) + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state;
  logic [data_width-1:0]     data_sh;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic                      par_bit;
  logic [prescale_width-1:0] pre_q;
  logic [prescale_width-1:0] cnt;
  logic [idx_width-1:0]      bit_idx;

  logic [prescale_width-1:0] eff_m1;
  logic                      bit_done;
  logic                      last_data;
  logic [data_width-1:0]     data_next;

  // A latched prescale of 0 behaves like 1, so the last count is 0 either way.
  assign eff_m1    = (pre_q == '0) ? '0 : pre_q - 1'b1;
  assign bit_done  = (cnt == eff_m1);
  assign last_data = (bit_idx == idx_width'(data_width - 1));
  assign data_next = data_sh >> 1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      TX_OUT    <= 1'b1;
      Busy      <= 1'b0;
      data_sh   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bit   <= 1'b0;
      pre_q     <= '0;
      cnt       <= '0;
      bit_idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT  <= 1'b1;
          Busy    <= 1'b0;
          cnt     <= '0;
          bit_idx <= '0;
          if (Data_Valid) begin
            data_sh   <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            pre_q     <= prescale;
            par_bit   <= PAR_TYP ? ~^P_DATA : ^P_DATA;
            TX_OUT    <= 1'b0;
            Busy      <= 1'b1;
            state     <= START;
          end
        end

        START: begin
          if (bit_done) begin
            cnt     <= '0;
            bit_idx <= '0;
            TX_OUT  <= data_sh[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // data_sh shifts right so the bit on the line is always taken from position 0.
        DATA: begin
          if (bit_done) begin
            cnt <= '0;
            if (last_data) begin
              if (par_en_q) begin
                TX_OUT <= par_bit;
                state  <= PARITY;
              end else begin
                TX_OUT <= 1'b1;
                state  <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              data_sh <= data_next;
              TX_OUT  <= data_next[0];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PARITY: begin
          if (bit_done) begin
            cnt    <= '0;
            TX_OUT <= 1'b1;
            state  <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_done) begin
            cnt    <= '0;
            TX_OUT <= 1'b1;
            Busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          TX_OUT <= 1'b1;
          Busy   <= 1'b0;
          cnt    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb/tb_uart_tx_frame.sv - self-checking bench for uart_tx_frame
// A per-cycle frame model runs beside directed literal checks of bit values and frame lengths.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] prescale = 6'd4;
  logic       TX_OUT;
  logic       Busy;

  uart_tx_frame #(.data_width(8), .prescale_width(6)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .prescale(prescale),
    .TX_OUT(TX_OUT), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a queue of line levels, one entry per clock of the frame.
  logic m_tx = 1'b1;
  logic m_busy = 1'b0;
  logic m_q[$];

  task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] pre);
    logic b[$];
    int eff;
    eff = (pre == 0) ? 1 : int'(pre);
    b.push_back(1'b0);
    for (int i = 0; i < 8; i++) b.push_back(d[i]);
    if (pe) b.push_back(pt ? ~^d : ^d);
    b.push_back(1'b1);
    foreach (b[i]) for (int j = 0; j < eff; j++) m_q.push_back(b[i]);
  endtask

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_q.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end else begin
      if (!m_busy && Data_Valid) build_frame(P_DATA, PAR_EN, PAR_TYP, prescale);
      if (m_q.size() > 0) begin
        m_tx   = m_q.pop_front();
        m_busy = 1'b1;
      end else begin
        m_tx   = 1'b1;
        m_busy = 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("model_tx", TX_OUT, m_tx);
      chk("model_busy", Busy, m_busy);
    end
  end

  logic rec[0:1023];
  int   rlen;

  task automatic record_frame(input logic [7:0] d, input logic pt, input int disturb);
    rlen = 0;
    while (Busy === 1'b1 && rlen < 1000) begin
      rec[rlen] = TX_OUT;
      rlen++;
      if (disturb != 0 && rlen == 10) begin
        P_DATA = ~d; PAR_TYP = ~pt; PAR_EN = 1'b1; prescale = 6'd2; Data_Valid = 1'b1;
      end
      if (disturb != 0 && rlen == 11) Data_Valid = 1'b0;
      @(negedge CLK);
    end
    Data_Valid = 1'b0;
    if (rlen >= 1000) chk("busy_timeout", 1, 0);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] pre,
                      input int disturb);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = pre; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    record_frame(d, pt, disturb);
  endtask

  task automatic check_bits(input string name, input int nbits, input int eff, input logic [15:0] vec);
    for (int i = 0; i < nbits; i++)
      chk($sformatf("%s_bit%0d", name, i), rec[i*eff + eff/2], vec[i]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int len1;

  initial begin
    repeat (3) @(negedge CLK);
    chk("reset_tx", TX_OUT, 1);
    chk("reset_busy", Busy, 0);
    RST = 1'b1;
    chk_en = 1'b1;

    send(8'hA5, 1'b0, 1'b0, 6'd4, 0);
    chk("8n1_len", rlen, 40);
    check_bits("8n1", 10, 4, 16'b1101001010);

    send(8'h07, 1'b1, 1'b0, 6'd4, 0);
    chk("even_len", rlen, 44);
    chk("even_par", rec[9*4+2], 1);

    send(8'h07, 1'b1, 1'b1, 6'd4, 0);
    chk("odd_len", rlen, 44);
    chk("odd_par", rec[9*4+2], 0);

    send(8'hFF, 1'b1, 1'b0, 6'd0, 0);
    chk("pre0_len", rlen, 11);
    check_bits("pre0", 11, 1, 16'b10111111110);

    send(8'hFF, 1'b1, 1'b0, 6'd1, 0);
    chk("pre1_len", rlen, 11);
    check_bits("pre1", 11, 1, 16'b10111111110);

    send(8'h3C, 1'b0, 1'b0, 6'd4, 1);
    chk("midchg_len", rlen, 40);
    check_bits("midchg", 10, 4, 16'b1001111000);
    repeat (20) @(negedge CLK);
    chk("midchg_no_second", Busy, 0);

    @(negedge CLK);
    P_DATA = 8'h55; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd4; Data_Valid = 1'b1;
    @(negedge CLK);
    P_DATA = 8'hAA;
    len1 = 0;
    while (Busy === 1'b1 && len1 < 1000) begin
      len1++;
      @(negedge CLK);
    end
    chk("b2b_len1", len1, 40);
    chk("b2b_gap_tx", TX_OUT, 1);
    chk("b2b_gap_busy", Busy, 0);
    @(negedge CLK);
    chk("b2b_second_busy", Busy, 1);
    Data_Valid = 1'b0;
    record_frame(8'hAA, 1'b0, 0);
    chk("b2b_len2", rlen, 40);
    check_bits("b2b", 10, 4, 16'b1101010100);

    @(negedge CLK);
    P_DATA = 8'h3C; PAR_EN = 1'b0; prescale = 6'd4; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    repeat (17) @(negedge CLK);
    chk("rst_pre_busy", Busy, 1);
    #2;
    RST = 1'b0;
    #1;
    chk("rst_async_tx", TX_OUT, 1);
    chk("rst_async_busy", Busy, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    send(8'h96, 1'b1, 1'b1, 6'd4, 0);
    chk("rst_after_len", rlen, 44);
    check_bits("rst_after", 11, 4, 16'b11100101100);

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
